vga_frame_renderer: RTL and testbench

- Consumer of the game-state VRAM's parallel word output.
- Generates 640x480@60 VGA timing from the 50 MHz system clock using an internal divide-by-2 pixel enable.
- Snapshots game-state words once per frame, during vertical blank, so objects never tear.
- Renders sky, ground, two pipe pairs and the bird as 24-bit RGB, with syncs, to the board's VGA DAC.

---
 rtl/vga_frame_renderer_if.sv | 26 ++
 rtl/vga_frame_renderer.sv | 166 ++++++++++++++++
 tb/tb_vga_frame_renderer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/vga_frame_renderer_if.sv
// Connects the game-state VRAM word bus to the renderer, and the renderer to the VGA DAC pins.
interface vga_frame_renderer_if #(
  parameter int N    = 32,
  parameter int SIZE = 10
);
  logic [SIZE-1:0][N-1:0] vram_words;
  logic                   vga_clk;
  logic                   hsync;
  logic                   vsync;
  logic                   blank_n;
  logic                   sync_n;
  logic [7:0]             red;
  logic [7:0]             green;
  logic [7:0]             blue;
  logic                   frame_start;

  modport master (
    input  vram_words,
    output vga_clk, hsync, vsync, blank_n, sync_n, red, green, blue, frame_start
  );

  modport slave (
    output vram_words,
    input  vga_clk, hsync, vsync, blank_n, sync_n, red, green, blue, frame_start
  );
endinterface

// File: rtl/vga_frame_renderer.sv
// 640x480@60 VGA renderer: latches the game state once per frame in vertical blank
// and paints sky, ground, two pipe pairs and the bird, with syncs, one pixel behind the counters.
module vga_frame_renderer #(
  parameter int N        = 32,
  parameter int SIZE     = 10,
  parameter int PIPE_W   = 52,
  parameter int GAP_H    = 120,
  parameter int BIRD_X   = 64,
  parameter int BIRD_SZ  = 16,
  parameter int GROUND_Y = 440
) (
  input logic                  clk,
  input logic                  rst,
  vga_frame_renderer_if.master bus
);

  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd751;
  localparam logic [9:0] H_MAX    = 10'd799;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd491;
  localparam logic [9:0] V_MAX    = 10'd524;

  localparam logic [11:0] BIRD_X0 = 12'(BIRD_X);
  localparam logic [11:0] BIRD_X1 = 12'(BIRD_X + BIRD_SZ);
  localparam logic [11:0] BIRD_S  = 12'(BIRD_SZ);
  localparam logic [11:0] PIPE_WD = 12'(PIPE_W);
  localparam logic [11:0] GAP_HT  = 12'(GAP_H);
  localparam logic [11:0] GND_Y   = 12'(GROUND_Y);

  localparam logic [23:0] C_BIRD  = 24'hFFD800;
  localparam logic [23:0] C_DEAD  = 24'hFF0000;
  localparam logic [23:0] C_PIPE  = 24'h00A000;
  localparam logic [23:0] C_GND   = 24'hDED895;
  localparam logic [23:0] C_SKY   = 24'h70C5CE;

  logic [SIZE-1:0][N-1:0] words;
  logic                   pix_en;
  logic [9:0]             h_cnt;
  logic [9:0]             v_cnt;
  logic [10:0]            bird_y;
  logic [10:0]            pipe0_x;
  logic [10:0]            pipe0_gap;
  logic [10:0]            pipe1_x;
  logic [10:0]            pipe1_gap;
  logic [10:0]            score;
  logic                   game_over;
  logic                   snap;
  logic                   frame_start_q;
  logic                   hsync_q;
  logic                   vsync_q;
  logic                   blank_q;
  logic [23:0]            rgb_q;
  logic [11:0]            h12;
  logic [11:0]            v12;
  logic                   visible;
  logic                   bird_hit;
  logic                   pipe0_hit;
  logic                   pipe1_hit;
  logic [23:0]            pix_rgb;
  logic                   unused_bits;

  assign words = bus.vram_words;

  // Score is held for a later overlay; the upper word bits carry nothing for this block.
  assign unused_bits = ^{words, score};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pix_en <= 1'b0;
    else     pix_en <= ~pix_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (pix_en) begin
      if (h_cnt == H_MAX) begin
        h_cnt <= 10'd0;
        v_cnt <= (v_cnt == V_MAX) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // First blank line, so every visible row of the coming frame sees one consistent state.
  assign snap = pix_en && (h_cnt == 10'd0) && (v_cnt == V_VIS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bird_y    <= 11'd0;
      pipe0_x   <= 11'd0;
      pipe0_gap <= 11'd0;
      pipe1_x   <= 11'd0;
      pipe1_gap <= 11'd0;
      score     <= 11'd0;
      game_over <= 1'b0;
    end else if (snap) begin
      bird_y    <= words[0][10:0];
      pipe0_x   <= words[1][10:0];
      pipe0_gap <= words[2][10:0];
      pipe1_x   <= words[3][10:0];
      pipe1_gap <= words[4][10:0];
      score     <= words[5][10:0];
      game_over <= words[6][0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_start_q <= 1'b0;
    else     frame_start_q <= snap;
  end

  function automatic logic pipe_at(input logic [11:0] h, input logic [11:0] v,
                                   input logic [10:0] x, input logic [10:0] gap);
    logic [11:0] x12;
    logic [11:0] g12;
    x12 = {1'b0, x};
    g12 = {1'b0, gap};
    return (h >= x12) && (h < x12 + PIPE_WD) && (v < GND_Y) &&
           !((v >= g12) && (v < g12 + GAP_HT));
  endfunction

  assign h12       = {2'b00, h_cnt};
  assign v12       = {2'b00, v_cnt};
  assign visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign bird_hit  = (h12 >= BIRD_X0) && (h12 < BIRD_X1) &&
                     (v12 >= {1'b0, bird_y}) && (v12 < {1'b0, bird_y} + BIRD_S);
  assign pipe0_hit = pipe_at(h12, v12, pipe0_x, pipe0_gap);
  assign pipe1_hit = pipe_at(h12, v12, pipe1_x, pipe1_gap);

  always_comb begin
    pix_rgb = C_SKY;
    if (bird_hit)                    pix_rgb = game_over ? C_DEAD : C_BIRD;
    else if (pipe0_hit || pipe1_hit) pix_rgb = C_PIPE;
    else if (v12 >= GND_Y)           pix_rgb = C_GND;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= 24'h000000;
    end else if (pix_en) begin
      hsync_q <= !((h_cnt >= H_SYNC_S) && (h_cnt <= H_SYNC_E));
      vsync_q <= !((v_cnt >= V_SYNC_S) && (v_cnt <= V_SYNC_E));
      blank_q <= visible;
      rgb_q   <= visible ? pix_rgb : 24'h000000;
    end
  end

  assign bus.vga_clk     = pix_en;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.blank_n     = blank_q;
  assign bus.sync_n      = 1'b0;
  assign bus.red         = rgb_q[23:16];
  assign bus.green       = rgb_q[15:8];
  assign bus.blue        = rgb_q[7:0];
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_frame_renderer.sv
// Directed bench for vga_frame_renderer: sync timing, mid-frame reset, snapshot timing and pixel colours.
module tb_vga_frame_renderer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   rel = 0;
  int   fs  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  vga_frame_renderer_if #(.N(32), .SIZE(10)) bus ();

  vga_frame_renderer #(
    .N(32), .SIZE(10), .PIPE_W(52), .GAP_H(120),
    .BIRD_X(64), .BIRD_SZ(16), .GROUND_Y(440)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_abs(input int t);
    while (cyc < t) step();
  endtask

  // Output for pixel (h,v) of the frame following the frame_start edge at base.
  task automatic chk_pix(input string tag, input int base, input int h, input int v,
                         input logic [23:0] exp);
    goto_abs(base + 2 * (36000 + v * 800 + h));
    check(tag, {8'h00, bus.red, bus.green, bus.blue}, {8'h00, exp});
  endtask

  task automatic set_words(input logic [10:0] w0, input logic [10:0] w1, input logic [10:0] w2,
                           input logic [10:0] w3, input logic [10:0] w4, input logic w6);
    bus.vram_words    = '0;
    bus.vram_words[0] = {21'd0, w0};
    bus.vram_words[1] = {21'd0, w1};
    bus.vram_words[2] = {21'd0, w2};
    bus.vram_words[3] = {21'd0, w3};
    bus.vram_words[4] = {21'd0, w4};
    bus.vram_words[6] = {31'd0, w6};
  endtask

  initial begin
    bus.vram_words = '0;
    repeat (3) step();
    check("rst_hsync",   {31'd0, bus.hsync},       32'd1);
    check("rst_vsync",   {31'd0, bus.vsync},       32'd1);
    check("rst_blank",   {31'd0, bus.blank_n},     32'd0);
    check("rst_rgb",     {8'h00, bus.red, bus.green, bus.blue}, 32'd0);
    check("rst_fs",      {31'd0, bus.frame_start}, 32'd0);
    check("rst_vga_clk", {31'd0, bus.vga_clk},     32'd0);
    check("sync_n",      {31'd0, bus.sync_n},      32'd0);

    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    goto_abs(rel + 1);
    check("vga_clk_hi", {31'd0, bus.vga_clk}, 32'd1);
    goto_abs(rel + 2);
    check("vga_clk_lo", {31'd0, bus.vga_clk}, 32'd0);

    // Counters sit at (300,200) after edge 320600; outputs still show (299,200).
    goto_abs(rel + 320601);
    check("mid_rgb",   {8'h00, bus.red, bus.green, bus.blue}, 32'h0070C5CE);
    check("mid_blank", {31'd0, bus.blank_n}, 32'd1);
    check("mid_vclk",  {31'd0, bus.vga_clk}, 32'd1);
    #5 rst = 1'b1;
    #1;
    check("abort_rgb",   {8'h00, bus.red, bus.green, bus.blue}, 32'd0);
    check("abort_blank", {31'd0, bus.blank_n}, 32'd0);
    check("abort_vclk",  {31'd0, bus.vga_clk}, 32'd0);
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    set_words(11'd100, 11'd200, 11'd150, 11'd700, 11'd0, 1'b0);

    goto_abs(rel + 1280);
    check("blank_639", {31'd0, bus.blank_n}, 32'd1);
    goto_abs(rel + 1282);
    check("blank_640", {31'd0, bus.blank_n}, 32'd0);
    goto_abs(rel + 1312);
    check("hs_pre", {31'd0, bus.hsync}, 32'd1);
    goto_abs(rel + 1314);
    check("hs_fall", {31'd0, bus.hsync}, 32'd0);
    goto_abs(rel + 1505);
    check("hs_last_low", {31'd0, bus.hsync}, 32'd0);
    goto_abs(rel + 1506);
    check("hs_rise", {31'd0, bus.hsync}, 32'd1);
    goto_abs(rel + 2912);
    check("hs2_pre", {31'd0, bus.hsync}, 32'd1);
    goto_abs(rel + 2914);
    check("hs2_fall", {31'd0, bus.hsync}, 32'd0);

    goto_abs(rel + 768001);
    check("fs_before", {31'd0, bus.frame_start}, 32'd0);
    goto_abs(rel + 768002);
    check("fs_pulse", {31'd0, bus.frame_start}, 32'd1);
    fs = cyc;
    goto_abs(fs + 1);
    check("fs_one_clk", {31'd0, bus.frame_start}, 32'd0);

    goto_abs(fs + 15998);
    check("vs_pre", {31'd0, bus.vsync}, 32'd1);
    goto_abs(fs + 16000);
    check("vs_fall", {31'd0, bus.vsync}, 32'd0);
    goto_abs(fs + 19198);
    check("vs_last_low", {31'd0, bus.vsync}, 32'd0);
    goto_abs(fs + 19200);
    check("vs_rise", {31'd0, bus.vsync}, 32'd1);

    chk_pix("sky_252_10", fs, 252, 10, 24'h70C5CE);
    // New state written mid-frame must not show until after the next snapshot.
    goto_abs(fs + 2 * (36000 + 50 * 800));
    set_words(11'd300, 11'd200, 11'd150, 11'd60, 11'd0, 1'b1);
    chk_pix("bird_64_100", fs, 64, 100, 24'hFFD800);
    check("blank_vis", {31'd0, bus.blank_n}, 32'd1);
    chk_pix("sky_80_100",   fs,  80, 100, 24'h70C5CE);
    chk_pix("bird_79_115",  fs,  79, 115, 24'hFFD800);
    chk_pix("pipe_200_149", fs, 200, 149, 24'h00A000);
    chk_pix("gap_200_150",  fs, 200, 150, 24'h70C5CE);
    chk_pix("gap_251_269",  fs, 251, 269, 24'h70C5CE);
    chk_pix("pipe_251_270", fs, 251, 270, 24'h00A000);
    chk_pix("old_64_300",   fs,  64, 300, 24'h70C5CE);
    chk_pix("gnd_200_440",  fs, 200, 440, 24'hDED895);
    chk_pix("gnd_64_450",   fs,  64, 450, 24'hDED895);
    chk_pix("black_640",    fs, 640, 450, 24'h000000);
    check("blank_off", {31'd0, bus.blank_n}, 32'd0);

    goto_abs(fs + 839999);
    check("fs2_before", {31'd0, bus.frame_start}, 32'd0);
    goto_abs(fs + 840000);
    check("fs2_period", {31'd0, bus.frame_start}, 32'd1);
    fs = cyc;

    chk_pix("moved_64_100", fs, 64, 100, 24'h70C5CE);
    chk_pix("pipe1_64_200", fs, 64, 200, 24'h00A000);
    chk_pix("dead_64_300",  fs, 64, 300, 24'hFF0000);
    chk_pix("dead_79_315",  fs, 79, 315, 24'hFF0000);
    chk_pix("pipe1_64_316", fs, 64, 316, 24'h00A000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
